serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Multi-cycle adder/subtractor controller. It sequences the existing 2-bit ripple_carry_adder slice over WIDTH-bit operands, 2 bits per clock, with a registered carry between slices. Operands enter and results leave over valid/ready handshakes. The block sits between the bot's control logic (odometry and sensor accumulators) and the shared 2-bit adder datapath.

Parameters:
WIDTH, 8, operand/result width in bits; must be even and >= 2.
SLICES, WIDTH/2, derived slice count; not overridable.

Ports:
clk_50M  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  operand request valid.
in_ready  output  1  block can accept operands; equals (state==IDLE).
op  input  1  0 = add (a+b+cin); 1 = subtract (a-b, cin ignored).
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in for add.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  registered result.
c_out  output  1  final carry; for subtract, 1 = no borrow.
ovf  output  1  two's-complement overflow.
busy  output  1  high in RUN or DONE.

Behaviour:
- FSM states are IDLE, RUN and DONE. Reset puts the FSM in IDLE and clears all output and data registers: out_valid=0, sum=0, c_out=0, ovf=0, busy=0. in_ready=1 in IDLE, including during reset.
- IDLE: on in_valid & in_ready:
  - Capture a into A_sh.
  - Capture b_eff = op ? ~b : b into B_sh.
  - Set carry = op ? 1 : cin.
  - Capture sign bits a[W-1] and b_eff[W-1].
  - Clear slice counter cnt=0 and go to RUN.
  - With no accept, stay in IDLE; inputs are don't-care.
- RUN, every edge:
  - The slice adds A_sh[1:0], B_sh[1:0] and carry.
  - Carry takes the slice c_out.
  - A_sh and B_sh shift right by 2.
  - The slice sum shifts into R_sh[W-1:W-2]; R_sh shifts right by 2.
  - cnt increments.
- When cnt==SLICES-1 the edge completes the last slice. On that edge:
  - Load sum <= final R_sh value, c_out <= final carry.
  - Load ovf <= (a_sign==b_sign) && (sum[W-1]!=a_sign).
  - Set out_valid=1 and go to DONE.
- Latency: out_valid is visible exactly SLICES cycles after the accepting edge (4 for WIDTH=8).
- DONE: hold sum, c_out, ovf and out_valid stable while out_ready=0.
  - On out_valid & out_ready: clear out_valid and return to IDLE.
  - The next accept happens no earlier than the following edge. There is no overlap: in_ready=0 in RUN and DONE.
- in_valid asserted in RUN or DONE is ignored and not queued. The requester must hold it until in_ready.
- cnt width is clog2(SLICES), minimum 1 bit. The counter never wraps past SLICES-1.
- Arithmetic is modulo 2^WIDTH.
- Reset mid-operation, in RUN or DONE: the next state is IDLE, the pending result is discarded, and outputs are cleared as above. Reset takes priority over any simultaneous handshake.
- WIDTH=2: RUN lasts one cycle.

Decomposition:
- Shared package/header (serial_adder_pkg): FSM state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2, and the OP_ADD/OP_SUB constants.
- One sub-module: instantiate the existing ripple_carry_adder (2-bit slice) as the datapath.
- The controller holds only the FSM, shift registers, carry register and counter. No other hierarchy.

Test Plan:
1. Basic add, WIDTH=8, op=0: a=8'h5A, b=8'h3C, cin=0.
   - out_valid exactly 4 cycles after accept.
   - sum=8'h96, c_out=0, ovf=1.
2. Carry chain, op=0: a=8'hFF, b=8'h01, cin=1.
   - sum=8'h01, c_out=1, ovf=0.
3. Subtract, op=1:
   - 8'h10-8'h20 gives sum=8'hF0, c_out=0, ovf=0.
   - 8'h80-8'h01 gives sum=8'h7F, c_out=1, ovf=1.
   - cin=1 has no effect on either case.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid, while presenting a second in_valid.
   - sum, c_out and ovf stay stable; in_ready=0 and the second request is not accepted.
   - Raise out_ready: IDLE follows; the second op is accepted on the next edge and completes correctly.
5. Reset mid-RUN: assert reset for 1 cycle on the 2nd RUN cycle.
   - Next cycle: IDLE, out_valid=0, sum=0, busy=0, in_ready=1.
   - A subsequent 8'h01+8'h01 gives 8'h02.
6. WIDTH=2 build: a=2'b11, b=2'b01, cin=0.
   - out_valid 1 cycle after accept.
   - sum=2'b00, c_out=1, ovf=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder/subtractor controller.
// Holds the FSM state encoding and the operation select constants
// used by the controller and by anything driving its op input.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/ripple_carry_adder.sv
// 2-bit ripple-carry adder slice, purely combinational.
// Ports:
//   a, b  : 2-bit addends
//   cin   : carry into bit 0
//   sum   : 2-bit sum
//   cout  : carry out of bit 1
module ripple_carry_adder (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] sum,
  output logic       cout
);

  logic c_mid;

  assign sum[0] = a[0] ^ b[0] ^ cin;
  assign c_mid  = (a[0] & b[0]) | (a[0] & cin) | (b[0] & cin);
  assign sum[1] = a[1] ^ b[1] ^ c_mid;
  assign cout   = (a[1] & b[1]) | (a[1] & c_mid) | (b[1] & c_mid);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Multi-cycle adder/subtractor controller. Feeds WIDTH-bit operands
// through a shared 2-bit ripple_carry_adder slice, two bits per clock,
// LSB slice first, with the carry registered between slices.
// WIDTH must be even and at least 2.
//
// state  | meaning
// -------+-------------------------------------------------------
// IDLE   | in_ready=1, waiting for in_valid to capture operands
// RUN    | one 2-bit slice per clock, cnt counts slices done
// DONE   | result held with out_valid=1 until out_ready
//
// Ports:
//   clk_50M, reset        : clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (op, a, b, cin)
//   out_valid / out_ready : result handshake (sum, c_out, ovf)
//   busy                  : high while in RUN or DONE
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_50M,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             busy
);

  localparam int SLICES = WIDTH / 2;
  localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLICES - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             carry;
  logic             a_sign;
  logic             b_sign;
  logic [CNT_W-1:0] cnt;

  logic [1:0]       slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] r_next;

  ripple_carry_adder u_slice (
    .a    (a_sh[1:0]),
    .b    (b_sh[1:0]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Subtract is a + ~b + 1: invert b here, force carry-in to 1 on accept.
  assign b_eff = (op == OP_SUB) ? ~b : b;

  // Written as shift-and-or so it also holds for WIDTH=2, where the
  // new slice lands directly in bits [1:0].
  assign r_next = (r_sh >> 2) | (WIDTH'(slice_sum) << (WIDTH - 2));

  assign in_ready = (state == S_IDLE);

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state     <= S_IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      r_sh      <= '0;
      carry     <= 1'b0;
      a_sign    <= 1'b0;
      b_sign    <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh   <= a;
            b_sh   <= b_eff;
            r_sh   <= '0;
            carry  <= (op == OP_SUB) ? 1'b1 : cin;
            a_sign <= a[WIDTH-1];
            b_sign <= b_eff[WIDTH-1];
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh  <= a_sh >> 2;
          b_sh  <= b_sh >> 2;
          r_sh  <= r_next;
          carry <= slice_cout;
          if (cnt == CNT_LAST) begin
            sum       <= r_next;
            c_out     <= slice_cout;
            ovf       <= (a_sign == b_sign) && (r_next[WIDTH-1] != a_sign);
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: a WIDTH=8 and a WIDTH=2
// instance on a shared clock and reset. Directed vectors come from a
// table of hand-computed results; random operations are checked against
// an integer-arithmetic model of add/subtract with carry and overflow.
module tb_serial_adder_ctrl;

  logic clk_50M = 1'b0;
  logic reset;
  always #5 clk_50M = ~clk_50M;

  logic       in_valid, in_ready, op, cin, out_valid, out_ready, c_out, ovf, busy;
  logic [7:0] a, b, sum;

  logic       in_valid2, in_ready2, op2, cin2, out_valid2, out_ready2, c_out2, ovf2, busy2;
  logic [1:0] a2, b2, sum2;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk_50M(clk_50M), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf), .busy(busy)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk_50M(clk_50M), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .op(op2), .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .c_out(c_out2), .ovf(ovf2), .busy(busy2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Returns {ovf, c_out, sum} for a w-bit operation, from plain integer math.
  function automatic logic [31:0] model(input int w, input logic o, input int ia,
                                        input int ib, input logic ci);
    int mod, half, full, sa, sb, sr;
    logic cy, ov;
    mod  = 1 << w;
    half = mod / 2;
    full = o ? (ia + (mod - 1 - ib) + 1) : (ia + ib + int'(ci));
    cy   = (full >= mod);
    sa   = (ia >= half) ? ia - mod : ia;
    sb   = (ib >= half) ? ib - mod : ib;
    sr   = o ? (sa - sb) : (sa + sb + int'(ci));
    ov   = (sr >= half) || (sr < -half);
    return (32'(ov) << (w + 1)) | (32'(cy) << w) | 32'(full % mod);
  endfunction

  // Waits for in_ready, accepts one operation, checks latency and result,
  // then consumes it. All driving/sampling happens 1 time unit after an edge.
  task automatic run8(input string tag, input logic o, input logic [7:0] ia,
                      input logic [7:0] ib, input logic ci, input logic [9:0] exp);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk_50M); #1; guard++;
    end
    check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    op = o; a = ia; b = ib; cin = ci; in_valid = 1'b1;
    @(posedge clk_50M); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); op = 1'($urandom);
    check({tag, " busy after accept"}, {31'd0, busy, in_ready}, 32'd2);
    lat = 0;
    while (!out_valid && lat < 12) begin
      @(posedge clk_50M); #1; lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd4);
    check({tag, " result"}, {22'd0, ovf, c_out, sum}, {22'd0, exp});
    out_ready = 1'b1;
    @(posedge clk_50M); #1;
    out_ready = 1'b0;
    check({tag, " back to idle"}, {29'd0, out_valid, in_ready, busy}, 32'd2);
  endtask

  task automatic run2(input string tag, input logic o, input logic [1:0] ia,
                      input logic [1:0] ib, input logic ci, input logic [3:0] exp);
    int lat;
    op2 = o; a2 = ia; b2 = ib; cin2 = ci; in_valid2 = 1'b1;
    @(posedge clk_50M); #1;
    in_valid2 = 1'b0;
    a2 = 2'($urandom); b2 = 2'($urandom);
    lat = 0;
    while (!out_valid2 && lat < 6) begin
      @(posedge clk_50M); #1; lat++;
    end
    check({tag, " w2 latency"}, 32'(lat), 32'd1);
    check({tag, " w2 result"}, {28'd0, ovf2, c_out2, sum2}, {28'd0, exp});
    out_ready2 = 1'b1;
    @(posedge clk_50M); #1;
    out_ready2 = 1'b0;
    check({tag, " w2 idle"}, {30'd0, out_valid2, in_ready2}, 32'd1);
  endtask

  typedef struct {
    string      name;
    logic       o;
    logic [7:0] ia;
    logic [7:0] ib;
    logic       ci;
    logic [7:0] es;
    logic       ec;
    logic       eo;
  } vec_t;

  vec_t vecs[6];
  logic [7:0] held_sum;
  logic [9:0] m8;
  logic [3:0] m2;
  int         guard;

  initial begin
    vecs[0] = '{"add_5a_3c",   1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{"add_carry",   1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{"sub_10_20",   1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0};
    vecs[3] = '{"sub_10_20_c", 1'b1, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[4] = '{"sub_80_01",   1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{"sub_80_01_c", 1'b1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};

    reset = 1'b1;
    in_valid = 1'b0; op = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    in_valid2 = 1'b0; op2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; out_ready2 = 1'b0;
    repeat (2) @(posedge clk_50M);
    #1;
    check("reset w8 outputs", {20'd0, sum, c_out, ovf, out_valid, busy}, 32'd0);
    check("reset w8 in_ready", 32'(in_ready), 32'd1);
    check("reset w2 outputs", {26'd0, sum2, c_out2, ovf2, out_valid2, busy2}, 32'd0);
    reset = 1'b0;
    @(posedge clk_50M); #1;

    for (int i = 0; i < 6; i++)
      run8(vecs[i].name, vecs[i].o, vecs[i].ia, vecs[i].ib, vecs[i].ci,
           {vecs[i].eo, vecs[i].ec, vecs[i].es});

    // Backpressure: result held for 5 cycles while a second request waits.
    op = 1'b0; a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk_50M); #1;
    a = 8'h70; b = 8'h10; cin = 1'b1; op = 1'b0;
    guard = 0;
    while (!out_valid && guard < 12) begin
      @(posedge clk_50M); #1; guard++;
    end
    check("bp first result", {22'd0, ovf, c_out, sum}, 32'h046);
    held_sum = sum;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_50M); #1;
      check($sformatf("bp hold cycle %0d", i),
            {20'd0, sum, c_out, ovf, out_valid, in_ready}, {20'd0, held_sum, 4'b0010});
    end
    out_ready = 1'b1;
    @(posedge clk_50M); #1;
    out_ready = 1'b0;
    check("bp idle after consume", {30'd0, out_valid, in_ready}, 32'd1);
    @(posedge clk_50M); #1;
    in_valid = 1'b0;
    check("bp second accepted", {30'd0, busy, in_ready}, 32'd2);
    guard = 0;
    while (!out_valid && guard < 12) begin
      @(posedge clk_50M); #1; guard++;
    end
    check("bp second latency", 32'(guard), 32'd4);
    check("bp second result", {22'd0, ovf, c_out, sum}, 32'h281);
    out_ready = 1'b1;
    @(posedge clk_50M); #1;
    out_ready = 1'b0;

    // Reset on the second RUN cycle discards the operation.
    op = 1'b0; a = 8'hAA; b = 8'h55; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk_50M); #1;
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk_50M); #1;
    reset = 1'b0;
    check("mid-run reset", {20'd0, sum, c_out, ovf, out_valid, busy, in_ready},
          32'd1);
    repeat (6) begin
      @(posedge clk_50M); #1;
      check("no result after reset", 32'(out_valid), 32'd0);
    end
    run8("post_reset_1p1", 1'b0, 8'h01, 8'h01, 1'b0, 10'h002);

    for (int i = 0; i < 40; i++) begin
      logic       o, ci;
      logic [7:0] ia, ib;
      o  = 1'($urandom);
      ci = 1'($urandom);
      ia = 8'($urandom);
      ib = 8'($urandom);
      m8 = 10'(model(8, o, int'(ia), int'(ib), ci));
      run8($sformatf("rand8_%0d", i), o, ia, ib, ci, m8);
    end

    run2("w2_3p1", 1'b0, 2'b11, 2'b01, 1'b0, 4'b0100);
    for (int i = 0; i < 16; i++) begin
      logic       o, ci;
      logic [1:0] ia, ib;
      o  = 1'($urandom);
      ci = 1'($urandom);
      ia = 2'($urandom);
      ib = 2'($urandom);
      m2 = 4'(model(2, o, int'(ia), int'(ib), ci));
      run2($sformatf("rand2_%0d", i), o, ia, ib, ci, m2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
